// File: rtl/command_arbiter_pkg.sv
// Shared types for the PSL command arbiter: command buffer line and status,
// arbiter state encoding and the requester count.
package command_arbiter_pkg;

  localparam int NUM_CMD_REQUESTERS = 4;
  localparam int CU_ID_BITS         = 8;
  localparam logic [CU_ID_BITS-1:0] INVALID_ID = 8'hFF;

  typedef enum logic [12:0] {
    INVALID    = 13'h0000,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60
  } command_t;

  typedef enum logic [2:0] {
    STRICT = 3'b000,
    ABORT  = 3'b001,
    PAGE   = 3'b010,
    PREF   = 3'b011,
    SPEC   = 3'b111
  } trans_order_t;

  typedef enum logic [2:0] {
    CMD_INVALID = 3'd0,
    CMD_READ    = 3'd1,
    CMD_WRITE   = 3'd2,
    CMD_WED     = 3'd3,
    CMD_RESTART = 3'd4
  } cmd_type_t;

  typedef struct packed {
    logic [CU_ID_BITS-1:0] cu_id;
    cmd_type_t             cmd_type;
  } CommandTag;

  typedef struct packed {
    logic         valid;
    command_t     command;
    logic [63:0]  address;
    logic [11:0]  size;
    trans_order_t abt;
    CommandTag    cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef enum logic [1:0] {
    ARB_RESET = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_ISSUE = 2'd2,
    ARB_STALL = 2'd3
  } arb_state;

  // Reset image of a command line: invalid everywhere, CU id marked invalid.
  function automatic CommandBufferLine empty_command_line();
    CommandBufferLine line;
    line.valid        = 1'b0;
    line.command      = INVALID;
    line.address      = 64'h0;
    line.size         = 12'h000;
    line.abt          = STRICT;
    line.cmd.cu_id    = INVALID_ID;
    line.cmd.cmd_type = CMD_INVALID;
    return line;
  endfunction

endpackage

// File: rtl/command_arbiter_round_robin.sv
// Combinational round-robin winner select: first set request at or after
// last_grant+1, wrapping around.
module round_robin_priority #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     requests,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_index
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // Scan the N positions starting just after the previous winner.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found_s     = 1'b0;
    idx_s       = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s = IDX_W'((int'(last_grant) + i) % N);
      if (requests[idx_s] && !found_s) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_index  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/command_arbiter.sv
// Round-robin arbiter sharing the PSL command buffer port between the WED
// controller (index 0) and the compute units, one holding slot per source.
module command_arbiter
  import command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CMD_REQUESTERS
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      enabled_in,
  input  BufferStatus               command_buffer_status,
  input  CommandBufferLine          command_in [NUM_REQUESTERS],
  output logic                      request_ready_out [NUM_REQUESTERS],
  output CommandBufferLine          command_out,
  output logic [NUM_REQUESTERS-1:0] grant_out,
  output logic [31:0]               issued_count_out
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic                      enabled_r;
  arb_state                  state_r;
  arb_state                  next_state_s;
  CommandBufferLine          slot_r [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] full_r;
  logic [IDX_W-1:0]          last_grant_r;
  CommandBufferLine          command_r;
  logic [NUM_REQUESTERS-1:0] grant_r;
  logic [31:0]               count_r;

  logic [NUM_REQUESTERS-1:0] winner_s;
  logic [IDX_W-1:0]          winner_idx_s;
  logic [NUM_REQUESTERS-1:0] grant_now_s;
  logic [NUM_REQUESTERS-1:0] ready_s;
  logic [NUM_REQUESTERS-1:0] accept_s;
  logic                      any_full_s;
  logic                      alfull_s;
  logic                      issue_s;
  CommandBufferLine          issue_line_s;
  logic                      unused_status_s;

  assign alfull_s        = command_buffer_status.alfull;
  assign unused_status_s = command_buffer_status.full ^ command_buffer_status.empty;
  assign any_full_s      = |full_r;
  assign issue_s         = enabled_r & ~alfull_s & any_full_s & (state_r == ARB_ISSUE);

  round_robin_priority #(
    .N     (NUM_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .requests    (full_r),
    .last_grant  (last_grant_r),
    .grant       (winner_s),
    .grant_index (winner_idx_s)
  );

  // A slot granted this cycle is free again, so its source may refill it now.
  always_comb begin
    grant_now_s  = '0;
    ready_s      = '0;
    accept_s     = '0;
    issue_line_s = slot_r[winner_idx_s];
    issue_line_s.valid = 1'b1;
    if (issue_s) begin
      grant_now_s = winner_s;
    end else begin
      grant_now_s = '0;
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      ready_s[i]           = ~full_r[i] | grant_now_s[i];
      accept_s[i]          = command_in[i].valid & ready_s[i];
      request_ready_out[i] = ready_s[i];
    end
  end

  // Enable register and arbiter state.
  always_ff @(posedge clock) begin
    if (rst) begin
      enabled_r <= 1'b0;
      state_r   <= ARB_RESET;
    end else begin
      enabled_r <= enabled_in;
      state_r   <= next_state_s;
    end
  end

  // Next-state logic; a stall takes precedence over going idle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_RESET: next_state_s = ARB_IDLE;
      ARB_IDLE: begin
        if (enabled_r && any_full_s) begin
          next_state_s = ARB_ISSUE;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (alfull_s) begin
          next_state_s = ARB_STALL;
        end else if (!any_full_s || !enabled_r) begin
          next_state_s = ARB_IDLE;
        end else begin
          next_state_s = ARB_ISSUE;
        end
      end
      ARB_STALL: begin
        if (!alfull_s && any_full_s && enabled_r) begin
          next_state_s = ARB_ISSUE;
        end else if (!enabled_r) begin
          next_state_s = ARB_IDLE;
        end else begin
          next_state_s = ARB_STALL;
        end
      end
      default: next_state_s = ARB_RESET;
    endcase
  end

  // Holding slots: a refill in the granting cycle wins over the clear.
  always_ff @(posedge clock) begin
    if (rst) begin
      full_r <= '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        slot_r[i] <= empty_command_line();
      end
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (accept_s[i]) begin
          slot_r[i] <= command_in[i];
          full_r[i] <= 1'b1;
        end else if (grant_now_s[i]) begin
          full_r[i] <= 1'b0;
        end else begin
          full_r[i] <= full_r[i];
        end
      end
    end
  end

  // Issue register, rotation pointer and saturating issue counter.
  always_ff @(posedge clock) begin
    if (rst) begin
      command_r    <= empty_command_line();
      grant_r      <= '0;
      count_r      <= 32'h0000_0000;
      last_grant_r <= IDX_W'(NUM_REQUESTERS - 1);
    end else if (issue_s) begin
      command_r    <= issue_line_s;
      grant_r      <= winner_s;
      last_grant_r <= winner_idx_s;
      if (count_r != 32'hFFFF_FFFF) begin
        count_r <= count_r + 32'd1;
      end else begin
        count_r <= count_r;
      end
    end else begin
      command_r.valid <= 1'b0;
      grant_r         <= '0;
    end
  end

  assign command_out      = command_r;
  assign grant_out        = grant_r;
  assign issued_count_out = count_r;

endmodule

// File: tb/tb_command_arbiter.sv
// Directed self-checking bench for command_arbiter; outputs are sampled 1 time
// unit after each rising edge, inputs are driven in the same window.
module tb_command_arbiter;
  import command_arbiter_pkg::*;

  logic             clock;
  logic             rst;
  logic             enabled;
  BufferStatus      status;
  CommandBufferLine cmd_in [4];
  logic             rdy [4];
  CommandBufferLine cmd_out;
  logic [3:0]       grant;
  logic [31:0]      count;
  logic [3:0]       rdy_v;

  int checks;
  int errors;

  assign rdy_v = {rdy[3], rdy[2], rdy[1], rdy[0]};

  command_arbiter #(.NUM_REQUESTERS(4)) dut (
    .clock                 (clock),
    .rst                   (rst),
    .enabled_in            (enabled),
    .command_buffer_status (status),
    .command_in            (cmd_in),
    .request_ready_out     (rdy),
    .command_out           (cmd_out),
    .grant_out             (grant),
    .issued_count_out      (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic CommandBufferLine make_cmd(input command_t c, input logic [63:0] a,
                                                input logic [7:0] cu);
    CommandBufferLine l;
    l.valid        = 1'b1;
    l.command      = c;
    l.address      = a;
    l.size         = 12'd128;
    l.abt          = STRICT;
    l.cmd.cu_id    = cu;
    l.cmd.cmd_type = CMD_READ;
    return l;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) cmd_in[i] = empty_command_line();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    enabled = 1'b1;
    status  = '0;
    clear_inputs();
    step();
    step();

    // Reset values
    check("rst_valid", 64'(cmd_out.valid), 64'h0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_ready", 64'(rdy_v), 64'hF);
    check("rst_command", 64'(cmd_out.command), 64'(INVALID));
    check("rst_cu_id", 64'(cmd_out.cmd.cu_id), 64'hFF);
    check("rst_state", 64'(dut.state_r), 64'(ARB_RESET));
    rst = 1'b0;
    step();

    // 1: single command from source 2, starting from idle
    cmd_in[2] = make_cmd(READ_CL_NA, 64'h1000, 8'd2);
    step();
    cmd_in[2] = empty_command_line();
    step();
    check("t1_early_valid", 64'(cmd_out.valid), 64'h0);
    step();
    check("t1_valid", 64'(cmd_out.valid), 64'h1);
    check("t1_grant", 64'(grant), 64'h4);
    check("t1_count", 64'(count), 64'h1);
    check("t1_addr", cmd_out.address, 64'h1000);
    check("t1_command", 64'(cmd_out.command), 64'(READ_CL_NA));
    step();
    check("t1_after_valid", 64'(cmd_out.valid), 64'h0);
    check("t1_after_grant", 64'(grant), 64'h0);

    // 2: all four slots full -> strict rotation 0,1,2,3
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) cmd_in[i] = make_cmd(READ_CL_S, 64'h2000 + 64'(i) * 64'h100, 8'(i));
    step();
    clear_inputs();
    check("t2_ready_full", 64'(rdy_v), 64'h0);
    step();
    for (int g = 0; g < 4; g++) begin
      step();
      check($sformatf("t2_grant%0d", g), 64'(grant), 64'(4'b0001 << g));
      check($sformatf("t2_addr%0d", g), cmd_out.address, 64'h2000 + 64'(g) * 64'h100);
    end
    check("t2_count", 64'(count), 64'h4);
    step();
    check("t2_end_valid", 64'(cmd_out.valid), 64'h0);

    // 3: slots 1 and 3 full while alfull is high for 5 cycles
    status.alfull = 1'b1;
    cmd_in[1] = make_cmd(WRITE_NA, 64'h3100, 8'd1);
    cmd_in[3] = make_cmd(WRITE_NA, 64'h3300, 8'd3);
    step();
    clear_inputs();
    check("t3_stall_valid0", 64'(cmd_out.valid), 64'h0);
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("t3_stall_valid%0d", k), 64'(cmd_out.valid), 64'h0);
    end
    check("t3_state", 64'(dut.state_r), 64'(ARB_STALL));
    check("t3_ready13", 64'({rdy[3], rdy[1]}), 64'h0);
    status.alfull = 1'b0;
    step();
    check("t3_resume_valid", 64'(cmd_out.valid), 64'h0);
    step();
    check("t3_grant1", 64'(grant), 64'h2);
    check("t3_addr1", cmd_out.address, 64'h3100);
    step();
    check("t3_grant3", 64'(grant), 64'h8);
    check("t3_addr3", cmd_out.address, 64'h3300);
    step();
    check("t3_end_valid", 64'(cmd_out.valid), 64'h0);
    check("t3_count", 64'(count), 64'h6);

    // 4: source 0 refills its slot in the cycle it is granted
    cmd_in[0] = make_cmd(READ_CL_NA, 64'h4000, 8'd0);
    cmd_in[1] = make_cmd(READ_CL_NA, 64'h4100, 8'd1);
    cmd_in[2] = make_cmd(READ_CL_NA, 64'h4200, 8'd2);
    step();
    clear_inputs();
    step();
    cmd_in[0] = make_cmd(WRITE_MI, 64'h4D00, 8'd0);
    check("t4_ready_refill", 64'(rdy[0]), 64'h1);
    step();
    cmd_in[0] = empty_command_line();
    check("t4_grant0", 64'(grant), 64'h1);
    check("t4_addr0", cmd_out.address, 64'h4000);
    check("t4_ready_held", 64'(rdy[0]), 64'h0);
    step();
    check("t4_grant1", 64'(grant), 64'h2);
    step();
    check("t4_grant2", 64'(grant), 64'h4);
    step();
    check("t4_grant0_new", 64'(grant), 64'h1);
    check("t4_addr_new", cmd_out.address, 64'h4D00);
    check("t4_command_new", 64'(cmd_out.command), 64'(WRITE_MI));
    step();
    check("t4_end_valid", 64'(cmd_out.valid), 64'h0);
    check("t4_count", 64'(count), 64'hA);

    // 5: reset lands exactly when an issue would have happened
    for (int i = 0; i < 3; i++) cmd_in[i] = make_cmd(READ_CL_S, 64'h5000 + 64'(i), 8'(i));
    step();
    clear_inputs();
    check("t5_ready_full", 64'(rdy_v), 64'h8);
    step();
    rst = 1'b1;
    step();
    check("t5_valid", 64'(cmd_out.valid), 64'h0);
    check("t5_grant", 64'(grant), 64'h0);
    check("t5_count", 64'(count), 64'h0);
    check("t5_ready", 64'(rdy_v), 64'hF);
    enabled = 1'b0;
    rst = 1'b0;
    step();
    step();
    check("t5_discarded_valid", 64'(cmd_out.valid), 64'h0);
    check("t5_discarded_count", 64'(count), 64'h0);

    // 6: disabled arbiter still accepts but does not issue
    cmd_in[0] = make_cmd(READ_CL_NA, 64'h6000, 8'd0);
    step();
    clear_inputs();
    check("t6_ready", 64'(rdy_v), 64'hE);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t6_disabled_valid%0d", k), 64'(cmd_out.valid), 64'h0);
    end
    enabled = 1'b1;
    step();
    step();
    check("t6_early_valid", 64'(cmd_out.valid), 64'h0);
    step();
    check("t6_valid", 64'(cmd_out.valid), 64'h1);
    check("t6_grant", 64'(grant), 64'h1);
    check("t6_addr", cmd_out.address, 64'h6000);
    check("t6_count", 64'(count), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
